// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: DMType codes, FSM
// encoding and the store-side alignment / lane helpers.
package mem_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_t;

  function automatic logic is_aligned(input logic [2:0] dm_type, input logic [1:0] off);
    logic ok;
    case (dm_type)
      DM_H, DM_HU: ok = (off[0] == 1'b0);
      DM_W:        ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] dm_type, input logic [1:0] off);
    logic [3:0] strb;
    case (dm_type)
      DM_H, DM_HU: strb = off[1] ? 4'b1100 : 4'b0011;
      DM_W:        strb = 4'b1111;
      default:     strb = 4'b0001 << off;
    endcase
    return strb;
  endfunction

  // Replicate the store lane so any strobe pattern picks up the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] dm_type, input logic [31:0] wdata);
    logic [31:0] data;
    case (dm_type)
      DM_H, DM_HU: data = {2{wdata[15:0]}};
      DM_W:        data = wdata;
      default:     data = {4{wdata[7:0]}};
    endcase
    return data;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select plus sign/zero extension of a 32-bit read word.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  dm_type,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte / halfword lane.
  always_comb begin
    case (addr)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    case (dm_type)
      DM_B:    data = {{24{byte_s[7]}}, byte_s};
      DM_H:    data = {{16{half_s[15]}}, half_s};
      DM_BU:   data = {24'h000000, byte_s};
      DM_HU:   data = {16'h0000, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one req/ack bus transaction per access,
// stalls the pipeline while it is outstanding and returns the extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  DMType_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        hold_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] read_data_out,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  ma_state_t   state_r, state_n;
  logic [CW-1:0] wait_cnt_r;
  logic [2:0]  dm_type_r;
  logic [1:0]  byte_off_r;
  logic        access_s, aligned_s;
  logic        latch_s, misalign_s, ack_done_s, timeout_s;
  logic [31:0] load_ext_s;

  assign access_s  = MemRead_in | MemWrite_in;
  assign aligned_s = is_aligned(DMType_in, addr_in[1:0]);

  mem_load_ext u_load_ext (
    .rdata   (dm_rdata),
    .addr    (byte_off_r),
    .dm_type (dm_type_r),
    .data    (load_ext_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= MA_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state, stall and per-cycle event strobes.
  always_comb begin
    state_n    = state_r;
    stall      = 1'b0;
    latch_s    = 1'b0;
    misalign_s = 1'b0;
    ack_done_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      MA_IDLE: begin
        if (access_s && aligned_s) begin
          latch_s = 1'b1;
          stall   = 1'b1;
          state_n = MA_REQ;
        end else if (access_s) begin
          misalign_s = 1'b1;
        end else begin
          state_n = MA_IDLE;
        end
      end
      MA_REQ: begin
        stall = 1'b1;
        // An ack in the final waiting cycle still completes the access.
        if (dm_ack) begin
          ack_done_s = 1'b1;
          state_n    = MA_DONE;
        end else if (wait_cnt_r == CW'(TIMEOUT - 1)) begin
          timeout_s = 1'b1;
          state_n   = MA_DONE;
        end else begin
          state_n = MA_REQ;
        end
      end
      MA_DONE: begin
        if (hold_in) begin
          state_n = MA_DONE;
        end else begin
          state_n = MA_IDLE;
        end
      end
      default: state_n = MA_IDLE;
    endcase
  end

  // Bus request fields and wait counter; fields stay stable while REQ is up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= 32'h0000_0000;
      dm_wstrb   <= 4'b0000;
      dm_wdata   <= 32'h0000_0000;
      dm_type_r  <= 3'b000;
      byte_off_r <= 2'b00;
      wait_cnt_r <= '0;
    end else if (latch_s) begin
      dm_req     <= 1'b1;
      dm_we      <= MemWrite_in;
      dm_addr    <= {addr_in[31:2], 2'b00};
      dm_wstrb   <= MemWrite_in ? store_strb(DMType_in, addr_in[1:0]) : 4'b0000;
      dm_wdata   <= MemWrite_in ? store_data(DMType_in, wdata_in) : 32'h0000_0000;
      dm_type_r  <= DMType_in;
      byte_off_r <= addr_in[1:0];
      wait_cnt_r <= '0;
    end else if (ack_done_s || timeout_s) begin
      dm_req <= 1'b0;
    end else if (state_r == MA_REQ) begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end else begin
      dm_req <= dm_req;
    end
  end

  // Load result and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_out <= 32'h0000_0000;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign_err <= misalign_s;
      bus_err      <= timeout_s;
      if (ack_done_s) begin
        read_data_out <= dm_we ? 32'h0000_0000 : load_ext_s;
      end else if (timeout_s || misalign_s) begin
        read_data_out <= 32'h0000_0000;
      end else begin
        read_data_out <= read_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit plus hand-written sequences
// for misalignment, timeout, hold in DONE and reset during REQ.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in, hold_in, dm_ack;
  logic [2:0]  DMType_in;
  logic [31:0] addr_in, wdata_in, dm_rdata;
  logic        dm_req, dm_we, stall, misalign_err, bus_err;
  logic [31:0] dm_addr, dm_wdata, read_data_out;
  logic [3:0]  dm_wstrb;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  dmt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic [31:0] exp_rd;
    logic        chk_wd;
  } vec_t;

  vec_t vecs[11];

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk (clk), .rst (rst),
    .MemRead_in (MemRead_in), .MemWrite_in (MemWrite_in),
    .DMType_in (DMType_in), .addr_in (addr_in), .wdata_in (wdata_in),
    .hold_in (hold_in),
    .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr),
    .dm_wstrb (dm_wstrb), .dm_wdata (dm_wdata),
    .dm_ack (dm_ack), .dm_rdata (dm_rdata),
    .read_data_out (read_data_out), .stall (stall),
    .misalign_err (misalign_err), .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] dmt,
                       input logic [31:0] addr, input logic [31:0] wdata);
    MemRead_in  = rd;
    MemWrite_in = wr;
    DMType_in   = dmt;
    addr_in     = addr;
    wdata_in    = wdata;
  endtask

  // Single access acked in its first REQ cycle.
  task automatic run_vec(input int idx, input vec_t v);
    step();
    drive(v.rd, v.wr, v.dmt, v.addr, v.wdata);
    dm_ack = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d c0 stall", idx), stall, 1'b1);
    check($sformatf("v%0d c0 req", idx), dm_req, 1'b0);
    step();
    dm_ack   = 1'b1;
    dm_rdata = v.rdata;
    @(negedge clk);
    check($sformatf("v%0d c1 req", idx), dm_req, 1'b1);
    check($sformatf("v%0d c1 stall", idx), stall, 1'b1);
    check($sformatf("v%0d addr", idx), dm_addr, v.exp_addr);
    check($sformatf("v%0d strb", idx), dm_wstrb, v.exp_strb);
    check($sformatf("v%0d we", idx), dm_we, v.exp_we);
    if (v.chk_wd) check($sformatf("v%0d wdata", idx), dm_wdata, v.exp_wdata);
    step();
    dm_ack = 1'b0;
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(negedge clk);
    check($sformatf("v%0d c2 stall", idx), stall, 1'b0);
    check($sformatf("v%0d c2 req", idx), dm_req, 1'b0);
    check($sformatf("v%0d rdata", idx), read_data_out, v.exp_rd);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, DM_W,  32'h100, 32'h0,  32'hDEADBEEF, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, DM_B,  32'h103, 32'h0,  32'h80112233, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, DM_BU, 32'h103, 32'h0,  32'h80112233, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, DM_HU, 32'h102, 32'h0,  32'h80112233, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h00008011, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, DM_H,  32'h102, 32'h0,  32'h80112233, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hFFFF8011, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, DM_H,  32'h100, 32'h0,  32'h80117FFF, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h00007FFF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, DM_B,  32'h201, 32'hAB, 32'h12345678, 32'h200, 4'b0010, 32'hABABABAB, 1'b1, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, DM_H,  32'h202, 32'hBEEF, 32'h12345678, 32'h200, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, DM_W,  32'h204, 32'h01234567, 32'h0, 32'h204, 4'b1111, 32'h01234567, 1'b1, 32'h0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, DM_B,  32'h102, 32'hC5, 32'h55555555, 32'h100, 4'b0100, 32'hC5C5C5C5, 1'b1, 32'h0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, DM_BU, 32'h101, 32'h0,  32'h80112233, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h00000022, 1'b0};

    rst = 1'b1;
    hold_in = 1'b0;
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(negedge clk);
    check("rst req", dm_req, 1'b0);
    check("rst we", dm_we, 1'b0);
    check("rst addr", dm_addr, 32'h0);
    check("rst strb", dm_wstrb, 4'b0000);
    check("rst wdata", dm_wdata, 32'h0);
    check("rst rdata", read_data_out, 32'h0);
    check("rst errs", {misalign_err, bus_err}, 2'b00);
    check("rst stall", stall, 1'b0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Misaligned LW: no request, no stall, one-cycle error, result cleared.
    step();
    drive(1'b1, 1'b0, DM_W, 32'h102, 32'h0);
    @(negedge clk);
    check("mis stall", stall, 1'b0);
    check("mis req", dm_req, 1'b0);
    step();
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(negedge clk);
    check("mis err", misalign_err, 1'b1);
    check("mis req2", dm_req, 1'b0);
    check("mis rdata", read_data_out, 32'h0);
    step();
    @(negedge clk);
    check("mis err end", misalign_err, 1'b0);

    // Misaligned SH.
    step();
    drive(1'b0, 1'b1, DM_H, 32'h201, 32'h1234);
    @(negedge clk);
    check("mis sh stall", stall, 1'b0);
    step();
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(negedge clk);
    check("mis sh err", misalign_err, 1'b1);
    check("mis sh req", dm_req, 1'b0);

    // Timeout with TIMEOUT=4: REQ in cycles 1..4, bus_err in cycle 5.
    run_vec(100, vecs[0]);
    step();
    drive(1'b1, 1'b0, DM_W, 32'h300, 32'h0);
    @(negedge clk);
    check("to c0 stall", stall, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      @(negedge clk);
      check($sformatf("to c%0d req", c), dm_req, 1'b1);
      check($sformatf("to c%0d stall", c), stall, 1'b1);
      check($sformatf("to c%0d buserr", c), bus_err, 1'b0);
    end
    step();
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(negedge clk);
    check("to c5 req", dm_req, 1'b0);
    check("to c5 buserr", bus_err, 1'b1);
    check("to c5 stall", stall, 1'b0);
    check("to c5 rdata", read_data_out, 32'h0);
    step();
    @(negedge clk);
    check("to c6 buserr", bus_err, 1'b0);

    // Ack in the last allowed cycle wins over the timeout.
    step();
    drive(1'b1, 1'b0, DM_W, 32'h304, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      @(negedge clk);
      check($sformatf("late c%0d req", c), dm_req, 1'b1);
    end
    step();
    dm_ack = 1'b1;
    dm_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("late c4 req", dm_req, 1'b1);
    step();
    dm_ack = 1'b0;
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(negedge clk);
    check("late rdata", read_data_out, 32'hCAFEF00D);
    check("late buserr", bus_err, 1'b0);
    check("late req", dm_req, 1'b0);

    // hold_in in DONE for 3 cycles with the load still presented.
    step();
    drive(1'b1, 1'b0, DM_W, 32'h108, 32'h0);
    step();
    dm_ack = 1'b1;
    dm_rdata = 32'h11223344;
    step();
    dm_ack = 1'b0;
    hold_in = 1'b1;
    @(negedge clk);
    check("hold rdata", read_data_out, 32'h11223344);
    for (int c = 2; c <= 4; c++) begin
      check($sformatf("hold c%0d req", c), dm_req, 1'b0);
      check($sformatf("hold c%0d stall", c), stall, 1'b0);
      step();
      @(negedge clk);
    end
    hold_in = 1'b0;
    check("hold c5 req", dm_req, 1'b0);
    check("hold c5 stall", stall, 1'b0);
    step();
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    @(negedge clk);
    check("hold c6 req", dm_req, 1'b0);

    // Reset asserted mid-REQ drops dm_req at once and returns to IDLE.
    step();
    drive(1'b1, 1'b0, DM_W, 32'h10C, 32'h0);
    step();
    @(negedge clk);
    check("rreq req", dm_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rreq req drop", dm_req, 1'b0);
    check("rreq stall acc", stall, 1'b1);
    drive(1'b0, 1'b0, DM_W, 32'h0, 32'h0);
    #1;
    check("rreq stall noacc", stall, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rreq after", dm_req, 1'b0);
    run_vec(200, vecs[10]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
